// File: rtl/coef_pkg.sv
// Shared definitions for the coefficient ROM sequencer: default sizes,
// the coefficient table and the sequencer state encoding.
package coef_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 8;
    localparam int ADR_W_DEF  = 3;
    localparam int CNT_W_DEF  = 4;
    localparam int TABLE_W    = 16;
    localparam int TABLE_N    = 8;

    // Series coefficients, entry 0 first
    localparam logic [TABLE_W-1:0] COEF_TABLE [TABLE_N] = '{
        16'hFFFF, 16'h5555, 16'h2222, 16'h0DD0,
        16'h0599, 16'h0244, 16'h00EE, 16'h005F
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    // Entries beyond the stored table read as zero so a larger DEPTH stays well defined
    function automatic logic [TABLE_W-1:0] coef_lookup(input int unsigned i);
        if (i < TABLE_N) begin
            return COEF_TABLE[i[2:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/coef_rom_core.sv
// Combinational coefficient lookup: adr selects one table entry.
module coef_rom_core
    import coef_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADR_W  = ADR_W_DEF
) (
    input  logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] data
);

    // Addresses at or past DEPTH return zero rather than aliasing into the table
    always_comb begin
        data = '0;
        if (32'(adr) < 32'(DEPTH)) begin
            data = DATA_W'(coef_lookup(32'(adr)));
        end
    end

endmodule

// File: rtl/coef_rom_seq.sv
// Coefficient sequencer: streams the first n table entries in index order
// over a registered valid/ready interface, with abort and a done pulse.
module coef_rom_seq
    import coef_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADR_W  = ADR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_terms,
    input  logic              abort,
    input  logic              ready,
    output logic [DATA_W-1:0] coef,
    output logic [ADR_W-1:0]  idx,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   n_q;
    logic [CNT_W-1:0]   n_d;
    logic [CNT_W-1:0]   n_clamp;
    logic [ADR_W-1:0]   idx_d;
    logic [DATA_W-1:0]  coef_d;
    logic               valid_d;
    logic               last_d;
    logic               busy_d;
    logic               done_d;
    logic [ADR_W-1:0]   rom_adr;
    logic [DATA_W-1:0]  rom_data;
    logic               xfer;

    coef_rom_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADR_W  (ADR_W)
    ) u_core (
        .adr  (rom_adr),
        .data (rom_data)
    );

    assign xfer    = valid && ready;
    assign n_clamp = (n_terms > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : n_terms;

    // Next-state and next-output logic; outputs hold unless a transition changes them
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx;
        coef_d  = coef;
        valid_d = valid;
        last_d  = last;
        busy_d  = busy;
        done_d  = 1'b0;
        rom_adr = idx;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_terms == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        n_d     = n_clamp;
                        rom_adr = '0;
                        idx_d   = '0;
                        coef_d  = rom_data;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        last_d  = (n_clamp == CNT_W'(1));
                    end
                end
            end
            RUN: begin
                if (abort || (xfer && last)) begin
                    state_d = FIN;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    rom_adr = idx + ADR_W'(1);
                    idx_d   = idx + ADR_W'(1);
                    coef_d  = rom_data;
                    last_d  = ((int'(idx) + 2) == int'(n_q));
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything and drops any run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx     <= '0;
            coef    <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx     <= idx_d;
            coef    <= coef_d;
            valid   <= valid_d;
            last    <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_coef_rom_seq.sv
// Directed self-checking bench for coef_rom_seq.
module tb_coef_rom_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  n_terms;
    logic        abort;
    logic        ready;
    logic [15:0] coef;
    logic [2:0]  idx;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;
    int beatCount   = 0;
    int beatBase    = 0;

    logic [15:0] tbTable [8] = '{
        16'hFFFF, 16'h5555, 16'h2222, 16'h0DD0,
        16'h0599, 16'h0244, 16'h00EE, 16'h005F
    };

    coef_rom_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n_terms (n_terms),
        .abort   (abort),
        .ready   (ready),
        .coef    (coef),
        .idx     (idx),
        .valid   (valid),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted beats as the consumer sees them
    always @(posedge clk) begin
        if (!rst && valid && ready) beatCount++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input logic [3:0] n, input bit a, input bit r);
        start   = s;
        n_terms = n;
        abort   = a;
        ready   = r;
    endtask

    task automatic checkOutput(input string tag, input bit eValid, input bit eLast,
                               input bit eBusy, input bit eDone, input bit chkData,
                               input logic [2:0] eIdx, input logic [15:0] eCoef);
        logic [22:0] obs;
        logic [22:0] exp;
        obs = {valid, last, busy, done, chkData ? idx : 3'b000, chkData ? coef : 16'h0000};
        exp = {eValid, eLast, eBusy, eDone, chkData ? eIdx : 3'b000, chkData ? eCoef : 16'h0000};
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s observed v/l/b/d=%b idx=%0d coef=%h expected v/l/b/d=%b idx=%0d coef=%h",
                   tag, obs[22:19], obs[18:16], obs[15:0], exp[22:19], exp[18:16], exp[15:0]);
        end
    endtask

    task automatic checkBeats(input string tag, input int expected);
        testsRun++;
        assert ((beatCount - beatBase) === expected) else begin
            testsFailed++;
            $error("FAIL %s observed beats=%0d expected beats=%0d", tag, beatCount - beatBase, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 4'd0, 0, 0);
        tick();
        tick();
        checkOutput("reset", 0, 0, 0, 0, 1, 3'd0, 16'h0000);
        rst = 1'b0;
        tick();
        checkOutput("idle after reset", 0, 0, 0, 0, 1, 3'd0, 16'h0000);

        // Basic three-beat run
        beatBase = beatCount;
        applyStimulus(1, 4'd3, 0, 1);
        tick();
        checkOutput("n3 beat0", 1, 0, 1, 0, 1, 3'd0, 16'hFFFF);
        start = 1'b0;
        tick();
        checkOutput("n3 beat1", 1, 0, 1, 0, 1, 3'd1, 16'h5555);
        tick();
        checkOutput("n3 beat2", 1, 1, 1, 0, 1, 3'd2, 16'h2222);
        tick();
        checkOutput("n3 fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        checkBeats("n3 beats", 3);
        tick();
        checkOutput("n3 idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000);

        // Stall on idx 1 for two cycles
        applyStimulus(1, 4'd3, 0, 1);
        tick();
        checkOutput("stall beat0", 1, 0, 1, 0, 1, 3'd0, 16'hFFFF);
        start = 1'b0;
        tick();
        checkOutput("stall beat1", 1, 0, 1, 0, 1, 3'd1, 16'h5555);
        ready = 1'b0;
        tick();
        checkOutput("stall hold1", 1, 0, 1, 0, 1, 3'd1, 16'h5555);
        tick();
        checkOutput("stall hold2", 1, 0, 1, 0, 1, 3'd1, 16'h5555);
        ready = 1'b1;
        tick();
        checkOutput("stall beat2", 1, 1, 1, 0, 1, 3'd2, 16'h2222);
        tick();
        checkOutput("stall fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        tick();

        // Clamp: n_terms above DEPTH streams the whole table
        beatBase = beatCount;
        applyStimulus(1, 4'd12, 0, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("clamp beat%0d", i), 1, (i == 7), 1, 0, 1, 3'(i), tbTable[i]);
            start = 1'b0;
            tick();
        end
        checkOutput("clamp fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        checkBeats("clamp beats", 8);
        tick();
        checkOutput("clamp idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000);

        // Zero-length run; start held into FIN must be ignored
        applyStimulus(1, 4'd0, 0, 1);
        tick();
        checkOutput("n0 fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        n_terms = 4'd3;
        tick();
        checkOutput("n0 idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000);
        start = 1'b0;
        tick();
        checkOutput("n0 start in fin ignored", 0, 0, 0, 0, 0, 3'd0, 16'h0000);

        // Abort coinciding with the idx 1 transfer
        beatBase = beatCount;
        applyStimulus(1, 4'd6, 0, 1);
        tick();
        checkOutput("abort beat0", 1, 0, 1, 0, 1, 3'd0, 16'hFFFF);
        start = 1'b0;
        tick();
        checkOutput("abort beat1", 1, 0, 1, 0, 1, 3'd1, 16'h5555);
        abort = 1'b1;
        tick();
        checkOutput("abort fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        abort = 1'b0;
        checkBeats("abort beats", 2);
        tick();
        checkOutput("abort idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000);

        // Reset in the middle of a run, then a single-beat run
        applyStimulus(1, 4'd6, 0, 1);
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("rst beat2", 1, 0, 1, 0, 1, 3'd2, 16'h2222);
        rst = 1'b1;
        tick();
        checkOutput("rst midrun", 0, 0, 0, 0, 1, 3'd0, 16'h0000);
        rst = 1'b0;
        tick();
        checkOutput("rst no done", 0, 0, 0, 0, 1, 3'd0, 16'h0000);
        applyStimulus(1, 4'd1, 0, 1);
        tick();
        checkOutput("n1 beat0", 1, 1, 1, 0, 1, 3'd0, 16'hFFFF);
        start = 1'b0;
        tick();
        checkOutput("n1 fin", 0, 0, 0, 1, 0, 3'd0, 16'h0000);
        tick();
        checkOutput("n1 idle", 0, 0, 0, 0, 0, 3'd0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
